// File: rtl/din_burst_gen_pkg.sv
// Shared types and default widths for the din burst generator.
package din_burst_pkg;
    localparam int DW_DEF    = 8;
    localparam int RW_DEF    = 4;
    localparam int DEPTH_DEF = 4;
    localparam int CW_DEF    = 8;

    typedef enum logic {IDLE, EMIT} state_t;

    typedef struct packed {
        logic [DW_DEF-1:0] value;
        logic [RW_DEF-1:0] rep;
    } cmd_t;
endpackage

// File: rtl/din_burst_gen_if.sv
// Command, compcounter stimulus and event-counter signals of the burst generator.
// master = controller/bench side, slave = din_burst_gen side.
interface din_burst_if #(
    parameter int DW = 8,
    parameter int RW = 4,
    parameter int CW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] cmd_value;
    logic [RW-1:0] cmd_repeat;
    logic [DW-1:0] din;
    logic          enb;
    logic          verdict;
    logic          cteal_15;
    logic          busy;
    logic [CW-1:0] verdict_cnt;
    logic [CW-1:0] c15_cnt;
    logic          cnt_clr;

    modport master (
        output cmd_valid, cmd_value, cmd_repeat, verdict, cteal_15, cnt_clr,
        input  cmd_ready, din, enb, busy, verdict_cnt, c15_cnt
    );

    modport slave (
        input  cmd_valid, cmd_value, cmd_repeat, verdict, cteal_15, cnt_clr,
        output cmd_ready, din, enb, busy, verdict_cnt, c15_cnt
    );
endinterface

// File: rtl/din_burst_gen_cmd_fifo.sv
// Command FIFO: registered pointers, combinational head read, no push/pop bypass.
// Full blocks push even when a pop happens in the same cycle; reset empties it.
module cmd_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_dat,
    output logic [W-1:0] o_dat,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == DEPTH[AW:0]);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dat   = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_dat;
    end
endmodule

// File: rtl/din_burst_gen.sv
// Replays queued (value, repeat) commands on din with enb for repeat+1 cycles each.
// First din one edge after acceptance; back-to-back commands without enb gap; cmd_ready = !full.
module din_burst_gen
    import din_burst_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int RW    = RW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic       clk,
    input  logic       rst,
    din_burst_if.slave bus
);
    state_t         r_state, w_state_nxt;
    logic [RW-1:0]  r_cnt, w_cnt_nxt;
    logic [DW-1:0]  r_din, w_din_nxt;
    logic           r_enb, w_enb_nxt;
    logic [CW-1:0]  r_vcnt;
    logic [CW-1:0]  r_c15cnt;
    logic           r_c15_prev;

    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [DW+RW-1:0] w_head;
    logic [DW-1:0]  w_head_value;
    logic [RW-1:0]  w_head_rep;

    cmd_fifo #(
        .W     (DW + RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.cmd_valid),
        .i_pop   (w_pop),
        .i_dat   ({bus.cmd_value, bus.cmd_repeat}),
        .o_dat   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_value = w_head[DW+RW-1:RW];
    assign w_head_rep   = w_head[RW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_din   <= '0;
            r_enb   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_din   <= w_din_nxt;
            r_enb   <= w_enb_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_din_nxt   = r_din;
        w_enb_nxt   = r_enb;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                w_enb_nxt = 1'b0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_din_nxt   = w_head_value;
                    w_cnt_nxt   = w_head_rep;
                    w_enb_nxt   = 1'b1;
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (!w_empty) begin
                    // Reload on the last cycle so consecutive commands abut.
                    w_pop     = 1'b1;
                    w_din_nxt = w_head_value;
                    w_cnt_nxt = w_head_rep;
                end else begin
                    w_enb_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_enb_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vcnt     <= '0;
            r_c15cnt   <= '0;
            r_c15_prev <= 1'b0;
        end else begin
            r_c15_prev <= bus.cteal_15;
            if (bus.cnt_clr) begin
                r_vcnt   <= '0;
                r_c15cnt <= '0;
            end else begin
                if (r_enb && bus.verdict && (r_vcnt != '1))
                    r_vcnt <= r_vcnt + 1'b1;
                if (bus.cteal_15 && !r_c15_prev && (r_c15cnt != '1))
                    r_c15cnt <= r_c15cnt + 1'b1;
            end
        end
    end

    assign bus.cmd_ready   = !w_full;
    assign bus.din         = r_din;
    assign bus.enb         = r_enb;
    assign bus.busy        = (r_state == EMIT) || !w_empty;
    assign bus.verdict_cnt = r_vcnt;
    assign bus.c15_cnt     = r_c15cnt;
endmodule

// File: tb/tb_din_burst_gen.sv
// Randomised and directed checks of din_burst_gen against a queue-based reference model.
module tb_din_burst_gen;
    import din_burst_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    din_burst_if #(.DW(8), .RW(4), .CW(8)) bus ();

    din_burst_gen #(.DW(8), .RW(4), .DEPTH(DEPTH), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending commands plus the remaining hold cycles of the current one.
    cmd_t       mq[$];
    cmd_t       mc;
    logic [7:0] m_din;
    logic       m_enb;
    int         m_rem;
    logic [7:0] m_vc;
    logic [7:0] m_cc;
    logic       m_prev;
    logic       m_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_din = 8'h00; m_enb = 1'b0; m_rem = 0;
            m_vc = 8'h00; m_cc = 8'h00; m_prev = 1'b0;
        end else begin
            m_acc = bus.cmd_valid && (mq.size() < DEPTH);
            if (bus.cnt_clr) begin
                m_vc = 8'h00;
                m_cc = 8'h00;
            end else begin
                if (m_enb && bus.verdict && m_vc != 8'hFF) m_vc = m_vc + 8'd1;
                if (bus.cteal_15 && !m_prev && m_cc != 8'hFF) m_cc = m_cc + 8'd1;
            end
            m_prev = bus.cteal_15;
            if (m_enb && m_rem > 1) begin
                m_rem = m_rem - 1;
            end else if (mq.size() > 0) begin
                mc    = mq.pop_front();
                m_din = mc.value;
                m_rem = int'(mc.rep) + 1;
                m_enb = 1'b1;
            end else begin
                m_enb = 1'b0;
            end
            if (m_acc) begin
                mc.value = bus.cmd_value;
                mc.rep   = bus.cmd_repeat;
                mq.push_back(mc);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("din",         {24'd0, bus.din},         {24'd0, m_din});
            chk("enb",         {31'd0, bus.enb},         {31'd0, m_enb});
            chk("busy",        {31'd0, bus.busy},        {31'd0, (m_enb || mq.size() > 0)});
            chk("cmd_ready",   {31'd0, bus.cmd_ready},   {31'd0, (mq.size() < DEPTH)});
            chk("verdict_cnt", {24'd0, bus.verdict_cnt}, {24'd0, m_vc});
            chk("c15_cnt",     {24'd0, bus.c15_cnt},     {24'd0, m_cc});
        end
    end

    // Capture of every enb-high din value and count of enb rising edges.
    logic [7:0] cap[$];
    int         rises;
    logic       enb_d;
    always @(negedge clk) begin
        if (bus.enb) cap.push_back(bus.din);
        if (bus.enb && !enb_d) rises++;
        enb_d = bus.enb;
    end

    // Called at posedge+2; returns at posedge+2 after the accepting edge.
    task automatic push(input logic [7:0] v, input logic [3:0] r);
        logic rdy;
        int   guard;
        guard = 0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_value  = v;
        bus.cmd_repeat = r;
        do begin
            @(negedge clk);
            rdy = bus.cmd_ready;
            @(posedge clk);
            #2;
            guard++;
        end while (!rdy && guard < 500);
        if (!rdy) chk("push_timeout", 32'd0, 32'd1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (bus.busy && guard < 3000);
        if (bus.busy) chk("idle_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic clear_cap();
        cap.delete();
        rises = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_seq[$];
        int         guard;
        n_vec = 0; n_err = 0; rises = 0; enb_d = 1'b0;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_value = 8'h00; bus.cmd_repeat = 4'h0;
        bus.verdict = 1'b0; bus.cteal_15 = 1'b0; bus.cnt_clr = 1'b0;
        #2;
        chk("rst_din",   {24'd0, bus.din},         32'h00);
        chk("rst_enb",   {31'd0, bus.enb},         32'h0);
        chk("rst_busy",  {31'd0, bus.busy},        32'h0);
        chk("rst_ready", {31'd0, bus.cmd_ready},   32'h1);
        chk("rst_vcnt",  {24'd0, bus.verdict_cnt}, 32'h00);
        chk("rst_c15",   {24'd0, bus.c15_cnt},     32'h00);
        #10 rst = 1'b0;
        @(posedge clk); #2;

        // Single-cycle command
        bus.cmd_valid = 1'b1; bus.cmd_value = 8'h01; bus.cmd_repeat = 4'h0;
        @(posedge clk); #2;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("t1_enb_on",  {31'd0, bus.enb}, 32'h1);
        chk("t1_din",     {24'd0, bus.din}, 32'h01);
        @(posedge clk); #1;
        chk("t1_enb_off", {31'd0, bus.enb},  32'h0);
        chk("t1_din_hold",{24'd0, bus.din},  32'h01);
        chk("t1_busy",    {31'd0, bus.busy}, 32'h0);
        #1;

        // Back-to-back commands form one 22-cycle window
        clear_cap();
        push(8'h05, 4'd9); push(8'h08, 4'd0); push(8'h02, 4'd0); push(8'hFE, 4'd9);
        wait_idle();
        exp_seq.delete();
        for (int i = 0; i < 10; i++) exp_seq.push_back(8'h05);
        exp_seq.push_back(8'h08);
        exp_seq.push_back(8'h02);
        for (int i = 0; i < 10; i++) exp_seq.push_back(8'hFE);
        chk("t2_len",   cap.size(), 32'd22);
        chk("t2_rises", rises,      32'd1);
        for (int i = 0; i < 22 && i < cap.size(); i++)
            chk("t2_seq", {24'd0, cap[i]}, {24'd0, exp_seq[i]});

        // FIFO fills behind a long command
        clear_cap();
        push(8'hAA, 4'd15);
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 4'd15);
        @(negedge clk);
        chk("t3_full_ready", {31'd0, bus.cmd_ready}, 32'h0);
        @(posedge clk); #2;
        push(8'h14, 4'd15);
        wait_idle();
        chk("t3_len", cap.size(), 32'd96);
        for (int i = 0; i < 96 && i < cap.size(); i++)
            chk("t3_seq", {24'd0, cap[i]}, (i < 16) ? 32'hAA : 32'h10 + 32'((i - 16) / 16));

        // verdict_cnt saturation, then clear priority
        bus.verdict = 1'b1;
        for (int i = 0; i < 19; i++) push(8'h40 + 8'(i), 4'd15);
        wait_idle();
        chk("t4_sat", {24'd0, bus.verdict_cnt}, 32'hFF);
        push(8'h77, 4'd3);
        guard = 0;
        do begin @(negedge clk); guard++; end while (!bus.enb && guard < 50);
        chk("t4_enb_seen", {31'd0, bus.enb}, 32'h1);
        @(posedge clk); #2;
        bus.cnt_clr = 1'b1;
        @(posedge clk); #1;
        chk("t4_clr", {24'd0, bus.verdict_cnt}, 32'h00);
        bus.cnt_clr = 1'b0;
        #1;
        bus.verdict = 1'b0;
        wait_idle();

        // cteal_15 rising-edge counting
        foreach (exp_seq[i]) exp_seq[i] = 8'h00;
        exp_seq.delete();
        exp_seq.push_back(8'd0); exp_seq.push_back(8'd1); exp_seq.push_back(8'd1);
        exp_seq.push_back(8'd0); exp_seq.push_back(8'd1);
        foreach (exp_seq[i]) begin
            bus.cteal_15 = exp_seq[i][0];
            @(posedge clk); #2;
        end
        repeat (3) begin @(posedge clk); #2; end
        @(negedge clk);
        chk("t5_c15", {24'd0, bus.c15_cnt}, 32'h02);
        @(posedge clk); #2;
        bus.cteal_15 = 1'b0;

        // Asynchronous reset while emitting with commands queued
        push(8'h33, 4'd15);
        push(8'h34, 4'd2); push(8'h35, 4'd2); push(8'h36, 4'd2);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t6_enb",   {31'd0, bus.enb},       32'h0);
        chk("t6_din",   {24'd0, bus.din},       32'h00);
        chk("t6_ready", {31'd0, bus.cmd_ready}, 32'h1);
        chk("t6_busy",  {31'd0, bus.busy},      32'h0);
        @(posedge clk); @(posedge clk);
        #3 rst = 1'b0;
        clear_cap();
        repeat (20) @(posedge clk);
        #2;
        chk("t6_no_residual", cap.size(), 32'd0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            bus.cmd_valid  = ($urandom_range(0, 2) == 0);
            bus.cmd_value  = 8'($urandom);
            bus.cmd_repeat = 4'($urandom_range(0, 3));
            bus.verdict    = 1'($urandom);
            bus.cteal_15   = 1'($urandom);
            bus.cnt_clr    = ($urandom_range(0, 40) == 0);
            @(posedge clk); #2;
        end
        bus.cmd_valid = 1'b0; bus.cnt_clr = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
